// File: rtl/reorder_buffer.sv
// In-order retirement buffer: multi-slot allocate, out-of-order completion, prefix retire.
// Completion visible 1 cycle later, registered retire 1 further cycle; alloc stalls unless ALLOC_W entries are free.
module reorder_buffer #(
  parameter int DEPTH      = 16,
  parameter int ALLOC_W    = 2,
  parameter int COMPLETE_W = 3,
  parameter int RETIRE_W   = 2,
  parameter int DATA_W     = 32,
  parameter int PREG_W     = 6,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic [ALLOC_W-1:0]           i_alloc_valid,
  input  logic [ALLOC_W*PREG_W-1:0]    i_alloc_preg_dst,
  input  logic [ALLOC_W*PREG_W-1:0]    i_alloc_old_preg,
  input  logic [ALLOC_W-1:0]           i_alloc_regwrite,
  input  logic [ALLOC_W-1:0]           i_alloc_memwrite,
  output logic                         o_alloc_ready,
  output logic [ALLOC_W*IDX_W-1:0]     o_alloc_rob_num,
  input  logic [COMPLETE_W-1:0]        i_cmpl_valid,
  input  logic [COMPLETE_W*IDX_W-1:0]  i_cmpl_rob_num,
  input  logic [COMPLETE_W*DATA_W-1:0] i_cmpl_data,
  output logic [RETIRE_W-1:0]          o_retire_valid,
  output logic [RETIRE_W*IDX_W-1:0]    o_retire_rob_num,
  output logic [RETIRE_W*PREG_W-1:0]   o_retire_preg_dst,
  output logic [RETIRE_W*PREG_W-1:0]   o_retire_old_preg,
  output logic [RETIRE_W*DATA_W-1:0]   o_retire_data,
  output logic [RETIRE_W-1:0]          o_retire_regwrite,
  output logic [RETIRE_W-1:0]          o_retire_memwrite,
  output logic [IDX_W:0]               o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  typedef struct packed {
    logic [PREG_W-1:0] preg_dst;
    logic [PREG_W-1:0] old_preg;
    logic [DATA_W-1:0] data;
    logic              regwrite;
    logic              memwrite;
  } entry_t;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ALLOC_C = (IDX_W+1)'(ALLOC_W);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_cmpl;
  entry_t           ent_dat [DEPTH];

  logic [IDX_W-1:0] slot_idx [ALLOC_W];
  logic [IDX_W:0]   alloc_num;
  logic             alloc_fire;
  logic [IDX_W-1:0] ret_idx [RETIRE_W];
  logic [RETIRE_W-1:0] ret_sel;
  logic [IDX_W:0]   ret_num;
  logic             ret_run;

  // Readiness looks only at registered occupancy, never at same-cycle retirements.
  assign o_alloc_ready = i_rst_n && !i_flush && ((DEPTH_C - count) >= ALLOC_C);
  assign alloc_fire    = o_alloc_ready && (|i_alloc_valid);
  assign o_count       = count;
  assign o_empty       = (count == '0);
  assign o_full        = (count == DEPTH_C);

  always_comb begin
    slot_idx        = '{default: '0};
    alloc_num       = '0;
    o_alloc_rob_num = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      slot_idx[k] = tail + alloc_num[IDX_W-1:0];
      o_alloc_rob_num[k*IDX_W +: IDX_W] = slot_idx[k];
      if (i_alloc_valid[k]) alloc_num = alloc_num + ONE_C;
    end
  end

  always_comb begin
    ret_idx = '{default: '0};
    ret_sel = '0;
    ret_num = '0;
    ret_run = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      ret_idx[i] = head + IDX_W'(i);
      if (ret_run && ent_vld[ret_idx[i]] && ent_cmpl[ret_idx[i]]) begin
        ret_sel[i] = 1'b1;
        ret_num    = ret_num + ONE_C;
      end else begin
        ret_run = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      ent_vld           <= '0;
      ent_cmpl          <= '0;
      o_retire_valid    <= '0;
      o_retire_rob_num  <= '0;
      o_retire_preg_dst <= '0;
      o_retire_old_preg <= '0;
      o_retire_data     <= '0;
      o_retire_regwrite <= '0;
      o_retire_memwrite <= '0;
    end else begin
      for (int p = 0; p < COMPLETE_W; p++) begin
        if (i_cmpl_valid[p] && ent_vld[i_cmpl_rob_num[p*IDX_W +: IDX_W]])
          ent_cmpl[i_cmpl_rob_num[p*IDX_W +: IDX_W]] <= 1'b1;
      end
      // Retire clears come after completion so a retiring entry always ends up empty.
      for (int i = 0; i < RETIRE_W; i++) begin
        if (ret_sel[i]) begin
          ent_vld[ret_idx[i]]  <= 1'b0;
          ent_cmpl[ret_idx[i]] <= 1'b0;
        end
        o_retire_valid[i]                    <= ret_sel[i];
        o_retire_rob_num[i*IDX_W +: IDX_W]   <= ret_sel[i] ? ret_idx[i] : '0;
        o_retire_preg_dst[i*PREG_W +: PREG_W] <= ret_sel[i] ? ent_dat[ret_idx[i]].preg_dst : '0;
        o_retire_old_preg[i*PREG_W +: PREG_W] <= ret_sel[i] ? ent_dat[ret_idx[i]].old_preg : '0;
        o_retire_data[i*DATA_W +: DATA_W]     <= ret_sel[i] ? ent_dat[ret_idx[i]].data : '0;
        o_retire_regwrite[i]                 <= ret_sel[i] && ent_dat[ret_idx[i]].regwrite;
        o_retire_memwrite[i]                 <= ret_sel[i] && ent_dat[ret_idx[i]].memwrite;
      end
      if (alloc_fire) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (i_alloc_valid[k]) begin
            ent_vld[slot_idx[k]]  <= 1'b1;
            ent_cmpl[slot_idx[k]] <= 1'b0;
          end
        end
      end
      head  <= head + ret_num[IDX_W-1:0];
      tail  <= tail + (alloc_fire ? alloc_num[IDX_W-1:0] : '0);
      count <= count + (alloc_fire ? alloc_num : '0) - ret_num;
    end
  end

  // Payload array carries no reset; validity bits above gate every use.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush) begin
      for (int p = 0; p < COMPLETE_W; p++) begin
        if (i_cmpl_valid[p] && ent_vld[i_cmpl_rob_num[p*IDX_W +: IDX_W]])
          ent_dat[i_cmpl_rob_num[p*IDX_W +: IDX_W]].data <= i_cmpl_data[p*DATA_W +: DATA_W];
      end
      if (alloc_fire) begin
        for (int k = 0; k < ALLOC_W; k++) begin
          if (i_alloc_valid[k]) begin
            ent_dat[slot_idx[k]] <= '{preg_dst: i_alloc_preg_dst[k*PREG_W +: PREG_W],
                                      old_preg: i_alloc_old_preg[k*PREG_W +: PREG_W],
                                      data:     '0,
                                      regwrite: i_alloc_regwrite[k],
                                      memwrite: i_alloc_memwrite[k]};
          end
        end
      end
    end
  end

endmodule
